menu_arrow_ctrl: RTL



---
 rtl/menu_arrow_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/menu_arrow_ctrl.sv
// Menu cursor controller: button presses move a highlighted index and arrow sprite; select blinks then confirms.
// Optional MENU_WRAP_EN: index wraps at the ends instead of saturating.
module menu_arrow_ctrl #(
  parameter int N_ITEMS        = 3,
  parameter int ITEM0_Y        = 190,
  parameter int ITEM_PITCH     = 40,
  parameter int ARROW_X        = 312,
  parameter int REPEAT_FRAMES  = 15,
  parameter int BLINK_FRAMES   = 8,
  parameter int CONFIRM_BLINKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       menu_en,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  output logic [9:0] arrow_x,
  output logic [9:0] arrow_y,
  output logic       arrow_visible,
  output logic [2:0] sel_index,
  output logic       sel_valid,
  output logic       busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_NAV     = 2'd1;
  localparam logic [1:0] S_CONFIRM = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int HW = $clog2(REPEAT_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int TW = $clog2(2 * CONFIRM_BLINKS + 1);

  localparam logic [2:0]    LAST_IDX  = 3'(N_ITEMS - 1);
  localparam logic [9:0]    Y_FIRST   = 10'(ITEM0_Y);
  localparam logic [9:0]    Y_LAST    = 10'(ITEM0_Y + (N_ITEMS - 1) * ITEM_PITCH);
  localparam logic [9:0]    PITCH     = 10'(ITEM_PITCH);
  localparam logic [9:0]    X_POS     = 10'(ARROW_X);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_FRAMES - 1);
  localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TOG_LAST  = TW'(2 * CONFIRM_BLINKS - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [9:0]    y_q, y_d;
  logic [9:0]    x_q;
  logic          vis_q, vis_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          up_prev_q, up_prev_d;
  logic          dn_prev_q, dn_prev_d;
  logic          sl_prev_q, sl_prev_d;
  logic [HW-1:0] hold_q, hold_d, hold_base;
  logic          hold_dir_q, hold_dir_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] tog_q, tog_d;
  logic          rep, move_up, move_dn;

  logic up_e, dn_e, sl_e, one_held;
  assign up_e     = btn_up & ~up_prev_q;
  assign dn_e     = btn_down & ~dn_prev_q;
  assign sl_e     = btn_select & ~sl_prev_q;
  assign one_held = btn_up ^ btn_down;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    y_d        = y_q;
    vis_d      = vis_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    up_prev_d  = 1'b0;
    dn_prev_d  = 1'b0;
    sl_prev_d  = 1'b0;
    hold_d     = hold_q;
    hold_dir_d = hold_dir_q;
    blink_d    = blink_q;
    tog_d      = tog_q;
    rep        = 1'b0;
    move_up    = 1'b0;
    move_dn    = 1'b0;
    hold_base  = (btn_down != hold_dir_q) ? '0 : hold_q;

    case (state_q)
      S_IDLE: begin
        vis_d  = 1'b0;
        busy_d = 1'b0;
        if (menu_en) begin
          state_d = S_NAV;
          sel_d   = 3'd0;
          y_d     = Y_FIRST;
          vis_d   = 1'b1;
          hold_d  = '0;
        end
      end
      S_NAV: begin
        // Edge history is kept only in NAV, so a button held on entry counts as a press.
        up_prev_d = btn_up;
        dn_prev_d = btn_down;
        sl_prev_d = btn_select;
        if (!one_held) begin
          hold_d = '0;
        end else begin
          hold_dir_d = btn_down;
          hold_d     = hold_base;
          if (frame_tick) begin
            if (hold_base == HOLD_LAST) begin
              hold_d = '0;
              rep    = 1'b1;
            end else begin
              hold_d = hold_base + HW'(1);
            end
          end
        end
        move_up = (up_e & ~dn_e) | (rep & btn_up);
        move_dn = (dn_e & ~up_e) | (rep & btn_down);
        if (sl_e) begin
          state_d = S_CONFIRM;
          busy_d  = 1'b1;
          blink_d = '0;
          tog_d   = '0;
          hold_d  = '0;
        end else if (move_up) begin
          if (sel_q == 3'd0) begin
`ifdef MENU_WRAP_EN
            sel_d = LAST_IDX;
            y_d   = Y_LAST;
`endif
          end else begin
            sel_d = sel_q - 3'd1;
            y_d   = y_q - PITCH;
          end
        end else if (move_dn) begin
          if (sel_q == LAST_IDX) begin
`ifdef MENU_WRAP_EN
            sel_d = 3'd0;
            y_d   = Y_FIRST;
`endif
          end else begin
            sel_d = sel_q + 3'd1;
            y_d   = y_q + PITCH;
          end
        end
      end
      S_CONFIRM: begin
        if (frame_tick) begin
          if (blink_q == BLNK_LAST) begin
            blink_d = '0;
            vis_d   = ~vis_q;
            tog_d   = tog_q + TW'(1);
            if (tog_q == TOG_LAST) begin
              valid_d = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end
      default: begin
        vis_d = 1'b1;
      end
    endcase

    // Leaving the menu overrides everything, including a confirm in progress.
    if (!menu_en) begin
      state_d = S_IDLE;
      vis_d   = 1'b0;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      hold_d  = '0;
      blink_d = '0;
      tog_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 3'd0;
      y_q        <= Y_FIRST;
      x_q        <= X_POS;
      vis_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      up_prev_q  <= 1'b0;
      dn_prev_q  <= 1'b0;
      sl_prev_q  <= 1'b0;
      hold_q     <= '0;
      hold_dir_q <= 1'b0;
      blink_q    <= '0;
      tog_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      y_q        <= y_d;
      x_q        <= X_POS;
      vis_q      <= vis_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      up_prev_q  <= up_prev_d;
      dn_prev_q  <= dn_prev_d;
      sl_prev_q  <= sl_prev_d;
      hold_q     <= hold_d;
      hold_dir_q <= hold_dir_d;
      blink_q    <= blink_d;
      tog_q      <= tog_d;
    end
  end

  assign arrow_x       = x_q;
  assign arrow_y       = y_q;
  assign arrow_visible = vis_q;
  assign sel_index     = sel_q;
  assign sel_valid     = valid_q;
  assign busy          = busy_q;

endmodule
